// File: rtl/stream_pkg.sv
// Shared stream helpers: counter-width function and handshake struct.
package stream_pkg;

   // Beat counter width for a given word/beat ratio, never below one bit.
   function automatic int unsigned beat_cnt_w(input int unsigned ratio);
      return ($clog2(ratio) > 0) ? 32'($clog2(ratio)) : 32'd1;
   endfunction

   typedef struct packed {
      logic valid;
      logic ready;
      logic last;
   } stream_hs_t;

endpackage

// File: rtl/stream_width_downsizer.sv
// Serializes wide valid/ready words into RATIO narrow beats, back-to-back
// words chained without a bubble.
module stream_width_downsizer
   import stream_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = 32,
   parameter int unsigned OUT_WIDTH = 8,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic                 in_last,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_last,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
   localparam int unsigned CW    = beat_cnt_w(RATIO);

   if (RATIO < 2 || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_params
      $error("stream_width_downsizer: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
   end

   logic [IN_WIDTH-1:0]               word;
   logic [RATIO-1:0][OUT_WIDTH-1:0]   slices;
   logic                              last_q;
   logic                              busy;
   logic [CW-1:0]                     cnt;
   logic [CW-1:0]                     sel;
   logic                              last_beat;
   logic                              accept;
   logic                              beat;

   assign last_beat = (cnt == CW'(RATIO - 1));
   assign in_ready  = !busy || (out_ready && last_beat);
   assign accept    = in_valid && in_ready;
   assign beat      = busy && out_ready;

   // Control state: busy flag, beat counter and packet-end flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         cnt    <= '0;
         last_q <= 1'b0;
      end else if (accept) begin
         busy   <= 1'b1;
         cnt    <= '0;
         last_q <= in_last;
      end else if (beat) begin
         if (last_beat) begin
            busy <= 1'b0;
            cnt  <= '0;
         end else begin
            cnt  <= cnt + CW'(1);
         end
      end
   end

   // Word register carries no reset; its content is ignored while idle.
   always_ff @(posedge clk) begin
      if (accept) begin
         word <= in_data;
      end
   end

   if (MSB_FIRST) begin : g_msb_first
      assign sel = CW'(RATIO - 1) - cnt;
   end else begin : g_lsb_first
      assign sel = cnt;
   end

   assign slices    = word;
   assign out_data  = slices[sel];
   assign out_valid = busy;
   assign out_last  = last_q && last_beat;

endmodule

// File: tb/tb_stream_width_downsizer.sv
// Randomized and directed check of stream_width_downsizer against a beat-queue model;
// a second instance with MSB_FIRST=1 shares the stimulus.
module tb_stream_width_downsizer;

   localparam int unsigned IW = 32;
   localparam int unsigned OW = 8;
   localparam int unsigned RT = IW / OW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [IW-1:0] in_data;
   logic          in_last;
   logic          in_valid;
   logic          in_ready;
   logic [OW-1:0] out_data;
   logic          out_last;
   logic          out_valid;
   logic          out_ready;
   logic          in_ready_m;
   logic [OW-1:0] out_data_m;
   logic          out_last_m;
   logic          out_valid_m;

   stream_width_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready));

   stream_width_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready_m), .out_data(out_data_m),
      .out_last(out_last_m), .out_valid(out_valid_m), .out_ready(out_ready));

   always #5 clk = ~clk;

   typedef struct {
      logic [OW-1:0] lsb;
      logic [OW-1:0] msb;
      logic          last;
   } beat_t;

   beat_t         q[$];
   logic [OW-1:0] obs[$];
   logic [OW-1:0] obs_m[$];
   int            n_vec = 0;
   int            n_err = 0;
   int            n_in_last = 0;
   int            n_out_last = 0;
   int            cyc = 0;
   logic          acc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: apply inputs, compare against the model, advance the model.
   task automatic step(input logic v, input logic [IW-1:0] d, input logic l, input logic r);
      logic exp_valid, exp_ready, mo, mi;
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = r;
      #3;
      exp_valid = (q.size() != 0);
      exp_ready = (q.size() == 0) || (r && q.size() == 1);
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("msb_out_valid", 32'(out_valid_m), 32'(exp_valid));
      if (exp_valid) begin
         check("out_data", 32'(out_data), 32'(q[0].lsb));
         check("out_last", 32'(out_last), 32'(q[0].last));
         check("msb_out_data", 32'(out_data_m), 32'(q[0].msb));
      end
      if (out_valid && r) begin
         obs.push_back(out_data);
         obs_m.push_back(out_data_m);
         if (out_last) n_out_last++;
      end
      mo  = exp_valid && r;
      mi  = v && exp_ready;
      acc = mi;
      @(posedge clk);
      #1;
      cyc++;
      if (mo) void'(q.pop_front());
      if (mi) begin
         for (int k = 0; k < int'(RT); k++) begin
            beat_t b;
            b.lsb  = OW'(d >> (OW * k));
            b.msb  = OW'(d >> (OW * (int'(RT) - 1 - k)));
            b.last = l && (k == int'(RT) - 1);
            q.push_back(b);
         end
         if (l) n_in_last++;
      end
   endtask

   task automatic send(input logic [IW-1:0] d, input logic l);
      int n = 0;
      do begin
         step(1'b1, d, l, 1'b1);
         n++;
      end while (!acc && n < 16);
      check("send_accepted", 32'(acc), 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 64) begin
         step(1'b0, '0, 1'b0, 1'b1);
         n++;
      end
      check("drain_done", 32'(q.size()), 32'd0);
   endtask

   task automatic expect_obs(input string tag, input logic [31:0] packed_lsb_first);
      logic [31:0] w;
      w = packed_lsb_first;
      check({tag, "_count"}, 32'(obs.size()), 32'(RT));
      for (int k = 0; k < int'(RT) && k < obs.size(); k++)
         check(tag, 32'(obs[k]), 32'(OW'(w >> (OW * k))));
   endtask

   initial begin
      int a1, a2, n;
      logic [IW-1:0] w;
      logic          l;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Single packet-ending word, both beat orders.
      obs.delete(); obs_m.delete(); n_out_last = 0;
      send(32'hAABBCCDD, 1'b1);
      drain();
      expect_obs("t1_lsb", 32'hAABBCCDD);
      for (int k = 0; k < int'(RT) && k < obs_m.size(); k++)
         check("t2_msb", 32'(obs_m[k]), 32'(OW'(32'hAABBCCDD >> (OW * (int'(RT) - 1 - k)))));
      check("t1_last_count", 32'(n_out_last), 32'd1);

      // Back-to-back words, no bubble.
      obs.delete(); obs_m.delete();
      send(32'h03020100, 1'b0); a1 = cyc;
      send(32'h07060504, 1'b0); a2 = cyc;
      drain();
      check("t3_accept_spacing", 32'(a2 - a1), 32'(RT));
      check("t3_count", 32'(obs.size()), 32'd8);
      for (int k = 0; k < 8 && k < obs.size(); k++)
         check("t3_beat", 32'(obs[k]), 32'(k));

      // Output stall on the second beat.
      obs.delete(); obs_m.delete();
      send(32'hAABBCCDD, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 32'h55555555, 1'b0, 1'b0);
         check("t4_hold_data", 32'(out_data), 32'hCC);
      end
      drain();
      expect_obs("t4_seq", 32'hAABBCCDD);

      // Async reset mid-word discards the remainder.
      send(32'hAABBCCDD, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(out_valid), 32'd0);
      check("t5_rst_last", 32'(out_last), 32'd0);
      check("t5_rst_ready", 32'(in_ready), 32'd1);
      q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      obs.delete(); obs_m.delete();
      send(32'h11223344, 1'b0);
      drain();
      expect_obs("t5_seq", 32'h11223344);

      // Random traffic scoreboard.
      n_in_last = 0; n_out_last = 0;
      for (int i = 0; i < 10000; i++) begin
         w = $urandom;
         l = ($urandom_range(0, 3) == 0);
         n = 0;
         do begin
            step(($urandom_range(0, 7) != 0), w, l, ($urandom_range(0, 15) != 0));
            n++;
         end while (!acc && n < 64);
         if (!acc) begin
            check("rand_accept_timeout", 32'(acc), 32'd1);
            break;
         end
      end
      drain();
      check("rand_last_count", 32'(n_out_last), 32'(n_in_last));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
